ycr1_arb_rr: RTL and testbench

//  Parametrised N-way round-robin arbiter with ack-held grants, per-requester burst

---
 rtl/ycr1_arb_rr_if.sv | 39 +++
 rtl/ycr1_arb_rr.sv | 156 +++++++++++++++
 tb/tb_ycr1_arb_rr.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ycr1_arb_rr_if.sv
// ----------------------------------------------------------------------------
// ycr1_arb_rr_if
//   Bundle of the arbiter's request/grant signals.
//   master modport : requester side (drives req/lock/ack, observes the grant)
//   slave  modport : arbiter side   (observes req/lock/ack, drives the grant)
//   Signals:
//     req      [NUM_REQ]  level request per master
//     lock     [NUM_REQ]  burst lock per master, honoured only for the grantee
//     ack                 slave completion of the current transfer
//     gnt      [NUM_REQ]  one-hot grant, zero when idle
//     gnt_idx  [IDX_W]    current or last granted master
//     gnt_vld             any grant active
//     tout_err            one-cycle watchdog revoke pulse
//     tout_idx [IDX_W]    master revoked by the most recent watchdog event
// ----------------------------------------------------------------------------
interface ycr1_arb_rr_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic               ack;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               tout_err;
    logic [IDX_W-1:0]   tout_idx;

    modport master (
        output req, lock, ack,
        input  gnt, gnt_idx, gnt_vld, tout_err, tout_idx
    );

    modport slave (
        input  req, lock, ack,
        output gnt, gnt_idx, gnt_vld, tout_err, tout_idx
    );
endinterface

// File: rtl/ycr1_arb_rr.sv
// ----------------------------------------------------------------------------
// ycr1_arb_rr
//   N-way round-robin arbiter putting core-side masters onto one shared slave
//   port. The grant is registered, held until the slave acks, and re-arbitrated
//   in the ack cycle so consecutive transfers have no idle bubble. A granted
//   master may hold the port across acks with its lock bit. An optional
//   watchdog revokes a grant that sees no ack for TIMEOUT cycles.
//   Parameters:
//     NUM_REQ   number of requesters (2..16)
//     FIXED_PRI 0 = round-robin, 1 = fixed priority (lowest index wins)
//     TIMEOUT   watchdog limit in cycles, 0 disables it
//     TO_W      watchdog counter width, TIMEOUT < 2**TO_W
//   Ports:
//     clk   clock
//     rstn  asynchronous active-low reset
//     bus   ycr1_arb_rr_if slave modport (req/lock/ack in, grant/status out)
// ----------------------------------------------------------------------------
module ycr1_arb_rr #(
    parameter int NUM_REQ   = 4,
    parameter int FIXED_PRI = 0,
    parameter int TIMEOUT   = 0,
    parameter int TO_W      = 8
) (
    input  logic         clk,
    input  logic         rstn,
    ycr1_arb_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_vld_q;
    logic               tout_err_q;
    logic [IDX_W-1:0]   tout_idx_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [TO_W-1:0]    wdog_q;

    logic [IDX_W-1:0]   ptr_d;       // pointer value taken when the grantee releases
    logic [IDX_W-1:0]   scan_ptr;
    logic               ack_unlocked;
    logic               timeout_hit;
    logic               release_gnt;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    // Slot visited at offset 'offs' from 'base', wrapping at NUM_REQ rather than
    // at 2**IDX_W so a non-power-of-two arbiter never addresses a missing slot.
    function automatic logic [IDX_W-1:0] slot_idx(input logic [IDX_W-1:0] base,
                                                  input int               offs);
        int pos;
        pos = int'(base) + offs;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        return IDX_W'(pos);
    endfunction

    // gnt_q is one-hot, so masking lock with it selects the grantee's lock bit;
    // lock bits of other masters drop out.
    assign ack_unlocked = bus.ack && !(|(gnt_q & bus.lock));
    assign timeout_hit  = (TIMEOUT > 0) && !bus.ack && (wdog_q == WDOG_LAST);
    assign release_gnt  = (state_q == ST_BUSY) && (ack_unlocked || timeout_hit);

    assign ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    // In BUSY the only decision that matters is the release one, which must
    // already see the advanced pointer so the releasing master goes last.
    assign scan_ptr = (FIXED_PRI != 0)       ? '0    :
                      (state_q == ST_BUSY)   ? ptr_d : ptr_q;

    // Scan from the highest offset down so the lowest offset with a request is
    // the last assignment and wins, without needing an early loop exit.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[slot_idx(scan_ptr, i)]) begin
                pick_vld = 1'b1;
                pick_idx = slot_idx(scan_ptr, i);
            end
        end
    end

    assign pick_oh = NUM_REQ'(1) << pick_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            tout_err_q <= 1'b0;
            tout_idx_q <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // decision in this cycle sees the pre-edge values of all registers.
            tout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q   <= ST_BUSY;
                        gnt_q     <= pick_oh;
                        gnt_idx_q <= pick_idx;
                        gnt_vld_q <= 1'b1;
                        wdog_q    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (release_gnt) begin
                        ptr_q  <= ptr_d;
                        wdog_q <= '0;
                        if (timeout_hit) begin
                            tout_err_q <= 1'b1;
                            tout_idx_q <= gnt_idx_q;
                        end
                        // Back-to-back handover; gnt_idx parks on the last
                        // grantee when nobody is waiting.
                        if (pick_vld) begin
                            gnt_q     <= pick_oh;
                            gnt_idx_q <= pick_idx;
                        end else begin
                            state_q   <= ST_IDLE;
                            gnt_q     <= '0;
                            gnt_vld_q <= 1'b0;
                        end
                    end else if (bus.ack) begin
                        // Locked ack: the burst continues with a fresh budget.
                        wdog_q <= '0;
                    end else if (TIMEOUT > 0) begin
                        wdog_q <= wdog_q + TO_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.gnt_vld  = gnt_vld_q;
    assign bus.tout_err = tout_err_q;
    assign bus.tout_idx = tout_idx_q;

endmodule

// File: tb/tb_ycr1_arb_rr.sv
// ----------------------------------------------------------------------------
// tb_ycr1_arb_rr
//   Three arbiter instances sharing clock and reset:
//     sel 0 : NUM_REQ=4, round-robin, TIMEOUT=5
//     sel 1 : NUM_REQ=4, fixed priority, no watchdog
//     sel 2 : NUM_REQ=3, round-robin, no watchdog
//   Each step drives one instance, queues the grant expected after the next
//   edge, and the queue is drained and compared once that edge has passed.
// ----------------------------------------------------------------------------
module tb_ycr1_arb_rr;

    logic clk;
    logic rstn;

    int checks = 0;
    int errors = 0;

    ycr1_arb_rr_if #(.NUM_REQ(4)) if_a ();
    ycr1_arb_rr_if #(.NUM_REQ(4)) if_f ();
    ycr1_arb_rr_if #(.NUM_REQ(3)) if_n ();

    ycr1_arb_rr #(.NUM_REQ(4), .FIXED_PRI(0), .TIMEOUT(5), .TO_W(8)) u_rr (
        .clk (clk), .rstn(rstn), .bus (if_a)
    );
    ycr1_arb_rr #(.NUM_REQ(4), .FIXED_PRI(1), .TIMEOUT(0), .TO_W(8)) u_fix (
        .clk (clk), .rstn(rstn), .bus (if_f)
    );
    ycr1_arb_rr #(.NUM_REQ(3), .FIXED_PRI(0), .TIMEOUT(0), .TO_W(8)) u_n3 (
        .clk (clk), .rstn(rstn), .bus (if_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       terr;
        logic [1:0] tidx;
    } obs_t;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       terr;
    } exp_t;

    exp_t sb[$];

    function automatic obs_t observe(input int sel);
        obs_t o;
        case (sel)
            0: begin
                o.gnt = if_a.gnt; o.idx = if_a.gnt_idx; o.vld = if_a.gnt_vld;
                o.terr = if_a.tout_err; o.tidx = if_a.tout_idx;
            end
            1: begin
                o.gnt = if_f.gnt; o.idx = if_f.gnt_idx; o.vld = if_f.gnt_vld;
                o.terr = if_f.tout_err; o.tidx = if_f.tout_idx;
            end
            default: begin
                o.gnt = {1'b0, if_n.gnt}; o.idx = if_n.gnt_idx; o.vld = if_n.gnt_vld;
                o.terr = if_n.tout_err; o.tidx = if_n.tout_idx;
            end
        endcase
        return o;
    endfunction

    task automatic drive(input int sel, input logic [3:0] req, input logic [3:0] lock,
                         input logic ack);
        case (sel)
            0:       begin if_a.req = req;      if_a.lock = lock;      if_a.ack = ack; end
            1:       begin if_f.req = req;      if_f.lock = lock;      if_f.ack = ack; end
            default: begin if_n.req = req[2:0]; if_n.lock = lock[2:0]; if_n.ack = ack; end
        endcase
    endtask

    task automatic zero_inputs();
        for (int s = 0; s < 3; s++) drive(s, 4'b0000, 4'b0000, 1'b0);
    endtask

    // Advance one edge, then pop and compare everything queued for it.
    task automatic tick();
        exp_t e;
        obs_t o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            if (o.gnt !== e.gnt || o.idx !== e.idx || o.vld !== (|e.gnt) || o.terr !== e.terr) begin
                errors++;
                $display("FAIL %s: got gnt=%b idx=%0d vld=%b terr=%b, want gnt=%b idx=%0d vld=%b terr=%b",
                         e.tag, o.gnt, o.idx, o.vld, o.terr, e.gnt, e.idx, |e.gnt, e.terr);
            end
        end
    endtask

    task automatic step(input int sel, input logic [3:0] req, input logic [3:0] lock,
                        input logic ack, input logic [3:0] eg, input logic [1:0] ei,
                        input logic et, input string tag);
        exp_t e;
        drive(sel, req, lock, ack);
        e.tag = tag; e.sel = sel; e.gnt = eg; e.idx = ei; e.terr = et;
        sb.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        zero_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        zero_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            o = observe(s);
            checks++;
            if (o.gnt !== 4'b0 || o.idx !== 2'd0 || o.vld !== 1'b0 || o.terr !== 1'b0 || o.tidx !== 2'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got gnt=%b idx=%0d vld=%b terr=%b tidx=%0d, want all zero",
                         s, o.gnt, o.idx, o.vld, o.terr, o.tidx);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_lock();
        do_reset();
        step(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, "lock_first_gnt");
        for (int k = 0; k < 3; k++)
            step(0, 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "lock_held_ack");
        step(0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, "lock_release");
        step(0, 4'b0101, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "lock_without_ack");
        // lock belongs to master 0, which is not granted: ack must release master 2
        step(0, 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "lock_non_granted");
        step(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "lock_to_idle");
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(0, 4'b1111, 4'b0000, 1'b0, 4'(1 << k), 2'(k), 1'b0, "rr_hold");
            step(0, 4'b1111, 4'b0000, 1'b1, 4'(1 << ((k + 1) % 4)), 2'((k + 1) % 4), 1'b0, "rr_next");
        end
        step(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "rr_idle_park");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_idle_stay");
    endtask

    task automatic test_watchdog();
        obs_t o;
        do_reset();
        step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_gnt");
        for (int k = 0; k < 4; k++)
            step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_count");
        step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, "wd_expire");
        o = observe(0);
        checks++;
        if (o.tidx !== 2'd1) begin
            errors++;
            $display("FAIL wd_tout_idx: got %0d, want 1", o.tidx);
        end
        for (int k = 0; k < 4; k++)
            step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_pulse_once");
        // ack in the expiry cycle wins: normal release, no error
        step(0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "wd_ack_wins");
        for (int k = 0; k < 4; k++)
            step(0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_count2");
        step(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, "wd_expire_move");
        for (int k = 0; k < 4; k++)
            step(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, "wd_count3");
        o = observe(0);
        checks++;
        if (o.tidx !== 2'd1) begin
            errors++;
            $display("FAIL wd_tout_idx_held: got %0d, want 1", o.tidx);
        end
        step(0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, "wd_expire_back");
        o = observe(0);
        checks++;
        if (o.tidx !== 2'd0) begin
            errors++;
            $display("FAIL wd_tout_idx2: got %0d, want 0", o.tidx);
        end
        step(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, "wd_to_idle");
    endtask

    task automatic test_fixed_pri();
        do_reset();
        for (int k = 0; k < 5; k++)
            step(1, 4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "fix_starve");
        step(1, 4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, "fix_alone");
        step(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, "fix_to_idle");
    endtask

    task automatic test_npot();
        do_reset();
        step(2, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, "n3_gnt2");
        step(2, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, "n3_regrant");
        step(2, 4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "n3_wrap");
        step(2, 4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "n3_next");
        step(2, 4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "n3_skip_missing");
        step(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "n3_to_idle");
    endtask

    task automatic test_reset_mid_grant();
        obs_t o;
        do_reset();
        step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "mid_gnt");
        for (int k = 0; k < 4; k++)
            step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, "mid_wait");
        step(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, "mid_expire");
        rstn = 1'b0;
        #1;
        o = observe(0);
        checks++;
        if (o.gnt !== 4'b0 || o.vld !== 1'b0 || o.terr !== 1'b0 || o.idx !== 2'd0 || o.tidx !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got gnt=%b vld=%b terr=%b idx=%0d tidx=%0d, want all zero",
                     o.gnt, o.vld, o.terr, o.idx, o.tidx);
        end
        step(0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "mid_held_in_reset");
        rstn = 1'b1;
        step(0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, "mid_after_release");
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        rstn = 1'b0;
        zero_inputs();
        test_reset();
        test_lock();
        test_rotation();
        test_watchdog();
        test_fixed_pri();
        test_npot();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
